wb_slave: RTL and testbench

- Wishbone classic single-transfer responder: the slave-side counterpart of the team's `wb_master`.
- Holds a DATA_COUNT-deep register array, decoded at BASE_ADDRESS.
- Sits behind each master interface (one-to-one directly, one-to-many through the interconnect); acks reads and writes after a programmable number of wait states.

---
 rtl/wb_slave.sv | 148 ++++++++++++++
 tb/tb_wb_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_slave.sv
// Wishbone classic single-transfer responder with a DATA_COUNT-deep register array.
// Optional: define WB_SLAVE_ERR_EN to complete address misses with err_o instead of ack_o.
module wb_slave #(
    parameter int unsigned BASE_ADDRESS = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_COUNT   = 16,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
);

    localparam int unsigned IDX_W = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_adr;
    logic [DATA_WIDTH-1:0] lat_dat;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] regs [DATA_COUNT];

    logic                  req_c;
    logic [ADDR_WIDTH-1:0] cur_adr_c;
    logic [DATA_WIDTH-1:0] cur_dat_c;
    logic                  cur_we_c;
    logic [ADDR_WIDTH:0]   offset_c;
    logic                  hit_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  enter_resp_c;

    assign req_c = cyc_i && stb_i;

    // In IDLE the live bus is the request; afterwards only the latched copy counts.
    assign cur_adr_c = (state == IDLE) ? adr_i : lat_adr;
    assign cur_dat_c = (state == IDLE) ? dat_i : lat_dat;
    assign cur_we_c  = (state == IDLE) ? we_i  : lat_we;

    // Borrow out of the subtraction flags addresses below the base.
    assign offset_c = {1'b0, cur_adr_c} - {1'b0, ADDR_WIDTH'(BASE_ADDRESS)};
    assign hit_c    = !offset_c[ADDR_WIDTH] &&
                      (offset_c[ADDR_WIDTH-1:0] < ADDR_WIDTH'(DATA_COUNT));
    assign idx_c    = IDX_W'(offset_c[ADDR_WIDTH-1:0]);

    assign enter_resp_c = (next_state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req_c) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!req_c) begin
                    next_state = IDLE;
                end else if (wait_cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            lat_adr  <= '0;
            lat_dat  <= '0;
            lat_we   <= 1'b0;
        end else if (state == IDLE) begin
            if (req_c) begin
                wait_cnt <= WAIT_INIT;
                lat_adr  <= adr_i;
                lat_dat  <= dat_i;
                lat_we   <= we_i;
            end
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Register file: a write lands on the edge that enters RESP, only on a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DATA_COUNT); i++) begin
                regs[i] <= '0;
            end
        end else if (enter_resp_c && cur_we_c && hit_c) begin
            regs[idx_c] <= cur_dat_c;
        end
    end

    // Response outputs are high only while in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_o <= '0;
            ack_o <= 1'b0;
        end else begin
            dat_o <= (enter_resp_c && !cur_we_c && hit_c) ? regs[idx_c] : '0;
`ifdef WB_SLAVE_ERR_EN
            ack_o <= enter_resp_c && hit_c;
`else
            ack_o <= enter_resp_c;
`endif
        end
    end

`ifdef WB_SLAVE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= enter_resp_c && !hit_c;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_slave.sv
// Randomized self-checking bench for wb_slave: two instances (base 0 / 0 waits, base 64 / 2 waits)
// checked against an array-based model of the register file and bus timing.
module tb_wb_slave;

    localparam int unsigned NREG = 16;
    localparam int unsigned B1   = 64;
    localparam int unsigned W1   = 2;
`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    logic [31:0] mem [2][NREG];
    int          n_checks;
    int          n_pass;

    wb_slave #(.BASE_ADDRESS(0), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(rdat[0]), .ack_o(ack[0]), .err_o(err[0])
    );

    wb_slave #(.BASE_ADDRESS(B1), .WAIT_STATES(W1)) u_dut1 (
        .clk(clk), .rst(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(rdat[1]), .ack_o(ack[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int unsigned base_of(input int s);
        return (s == 0) ? 0 : B1;
    endfunction

    function automatic int unsigned waits_of(input int s);
        return (s == 0) ? 0 : W1;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < int'(NREG); i++) mem[s][i] = '0;
    endtask

    // One transfer on instance s; abort_at>0 drops cyc/stb after that many cycles.
    task automatic xfer(input int s, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int abort_at);
        int          n;
        bit          done;
        bit          hit;
        logic [31:0] off;
        logic [31:0] exp_d;
        off = a - base_of(s);
        hit = (a >= base_of(s)) && (off < NREG);
        exp_d = (!wr && hit) ? mem[s][off[3:0]] : 32'h0;

        @(negedge clk);
        cyc[s] = 1'b1; stb[s] = 1'b1; we[s] = wr; adr[s] = a; wdat[s] = d;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack[s] || err[s]) begin
                done = 1'b1;
            end else if (abort_at > 0 && n == abort_at) begin
                break;
            end else begin
                adr[s] = $urandom; wdat[s] = $urandom; we[s] = ~we[s];
            end
        end

        if (abort_at > 0) begin
            check("abort_early_resp", 32'(done), 32'd0);
            cyc[s] = 1'b0; stb[s] = 1'b0;
            for (int i = 0; i < int'(W1) + 2; i++) begin
                @(negedge clk);
                check("abort_ack", 32'(ack[s]), 32'd0);
                check("abort_err", 32'(err[s]), 32'd0);
            end
            return;
        end

        check("resp_timeout", 32'(done), 32'd1);
        check("latency", 32'(n), 32'(waits_of(s) + 1));
        check("ack", 32'(ack[s]), 32'(hit || !ERR_EN));
        check("err", 32'(err[s]), 32'(!hit && ERR_EN));
        check(wr ? "wr_dat_o" : "rd_data", rdat[s], exp_d);
        if (wr && hit) mem[s][off[3:0]] = d;

        cyc[s] = 1'b0; stb[s] = 1'b0; adr[s] = $urandom; wdat[s] = $urandom;
        @(negedge clk);
        check("ack_single", 32'(ack[s]), 32'd0);
        check("dat_idle", rdat[s], 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wdat[i] = '0;
        end
        clear_model();
        rst = 1'b1;
        #23 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", 32'(ack[i]), 32'd0);
            check("rst_err", 32'(err[i]), 32'd0);
            check("rst_dat", rdat[i], 32'h0);
        end

        // Reset then read, write/readback on the zero-wait instance.
        xfer(0, 1'b0, 32'd3, 32'h0, 0);
        xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, 0);
        xfer(0, 1'b0, 32'd5, 32'h0, 0);
        xfer(0, 1'b0, 32'd4, 32'h0, 0);
        xfer(0, 1'b0, 32'd6, 32'h0, 0);

        // Full sweep on the two-wait instance.
        for (int i = 0; i < int'(NREG); i++) xfer(1, 1'b1, B1 + i, 32'(i) * 32'h11111111, 0);
        for (int i = 0; i < int'(NREG); i++) xfer(1, 1'b0, B1 + i, 32'h0, 0);

        // Just below and just above the decoded window; then confirm nothing moved.
        xfer(1, 1'b0, 32'd63, 32'h0, 0);
        xfer(1, 1'b0, 32'd80, 32'h0, 0);
        xfer(1, 1'b1, 32'd63, 32'hA5A5A5A5, 0);
        xfer(1, 1'b1, 32'd80, 32'h5A5A5A5A, 0);
        for (int i = 0; i < int'(NREG); i++) xfer(1, 1'b0, B1 + i, 32'h0, 0);

        // Aborted write leaves the old value in place.
        xfer(1, 1'b1, B1 + 1, 32'h12345678, 1);
        xfer(1, 1'b0, B1 + 1, 32'h0, 0);

        // Randomized mix of hits, misses and aborts on both instances.
        for (int k = 0; k < 250; k++) begin
            s = int'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = base_of(s) + NREG + $urandom_range(0, 20);
                1:       a = (s == 1) ? B1 - 1 - $urandom_range(0, 10) : $urandom;
                default: a = base_of(s) + $urandom_range(0, NREG - 1);
            endcase
            if (s == 1 && $urandom_range(0, 7) == 0)
                xfer(1, 1'($urandom), a, $urandom, int'($urandom_range(1, W1)));
            else
                xfer(s, 1'($urandom), a, $urandom, 0);
        end

        // Async reset while instance 1 waits and instance 0 is acking.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = B1 + 7; wdat[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'd5;
        @(posedge clk);
        #1;
        check("pre_rst_ack0", 32'(ack[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ack0", 32'(ack[0]), 32'd0);
        check("rst_mid_dat0", rdat[0], 32'h0);
        check("rst_mid_ack1", 32'(ack[1]), 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hold_ack1", 32'(ack[1]), 32'd0);
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, 32'($urandom_range(0, NREG - 1)), 32'h0, 0);
            xfer(1, 1'b0, B1 + $urandom_range(0, NREG - 1), 32'h0, 0);
        end
        xfer(1, 1'b0, B1 + 7, 32'h0, 0);
        xfer(0, 1'b0, 32'd5, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
